// File: rtl/ram_fifo_ctrl_if.sv
// FIFO controller bundle: upstream write/read handshake, status flags and the
// dual-port RAM connections (port A write-only, port B read-only).
interface ram_fifo_ctrl_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3
);
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;
    logic [ADDR_W-1:0] ram_addr_a;
    logic [DATA_W-1:0] ram_data_in_a;
    logic              ram_we_a;
    logic [ADDR_W-1:0] ram_addr_b;
    logic [DATA_W-1:0] ram_data_in_b;
    logic              ram_we_b;
    logic [DATA_W-1:0] ram_data_out_b;

    // User plus RAM side: drives requests and returns RAM read data
    modport master (
        output wr_en, wr_data, rd_en, ram_data_out_b,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty, count,
               overflow, underflow, ram_addr_a, ram_data_in_a, ram_we_a,
               ram_addr_b, ram_data_in_b, ram_we_b
    );

    modport slave (
        input  wr_en, wr_data, rd_en, ram_data_out_b,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty, count,
               overflow, underflow, ram_addr_a, ram_data_in_a, ram_we_a,
               ram_addr_b, ram_data_in_b, ram_we_b
    );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// Synchronous FIFO controller around an 8x8 dual-port RAM with a registered
// port-B read; owns pointers, occupancy, flags and error pulses.
module ram_fifo_ctrl #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned AF_TH  = 6,
    parameter int unsigned AE_TH  = 2
) (
    input  logic             clk,
    input  logic             rst,
    ram_fifo_ctrl_if.slave   bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned PTR_W = ADDR_W + 1;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             rd_valid_q, rd_valid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic full_c, empty_c, wr_acc_c, rd_acc_c;

    // Flags decode from the registered occupancy
    assign full_c  = (count_q == CNT_W'(DEPTH));
    assign empty_c = (count_q == CNT_W'(0));

    // A full FIFO refuses writes and an empty one refuses reads regardless of
    // the other side, so port A and port B never touch the same live entry.
    assign wr_acc_c = bus.wr_en & ~full_c;
    assign rd_acc_c = bus.rd_en & ~empty_c;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rd_valid_d  = 1'b0;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;

        wr_ptr_d    = wr_ptr_q + PTR_W'(wr_acc_c);
        rd_ptr_d    = rd_ptr_q + PTR_W'(rd_acc_c);
        count_d     = count_q + CNT_W'(wr_acc_c) - CNT_W'(rd_acc_c);
        rd_valid_d  = rd_acc_c;
        overflow_d  = bus.wr_en & full_c;
        underflow_d = bus.rd_en & empty_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // RAM drive: port A writes at the write pointer, port B always reads
    assign bus.ram_we_a      = wr_acc_c;
    assign bus.ram_addr_a    = wr_ptr_q[ADDR_W-1:0];
    assign bus.ram_data_in_a = bus.wr_data;
    assign bus.ram_addr_b    = rd_ptr_q[ADDR_W-1:0];
    assign bus.ram_data_in_b = DATA_W'(0);
    assign bus.ram_we_b      = 1'b0;

    // The RAM's output register supplies the one-cycle read latency
    assign bus.rd_data       = bus.ram_data_out_b;
    assign bus.rd_valid      = rd_valid_q;

    assign bus.count         = count_q;
    assign bus.full          = full_c;
    assign bus.empty         = empty_c;
    assign bus.almost_full   = (count_q >= CNT_W'(AF_TH));
    assign bus.almost_empty  = (count_q <= CNT_W'(AE_TH));
    assign bus.overflow      = overflow_q;
    assign bus.underflow     = underflow_q;
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: directed scenarios plus random traffic checked
// against a queue-based FIFO model, with a behavioural 8x8 dual-port RAM.
module tb_ram_fifo_ctrl;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DEPTH  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_fifo_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    ram_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .AF_TH(6), .AE_TH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural RAM: port A write, port B registered read
    logic [DATA_W-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (bus.ram_we_a) mem[bus.ram_addr_a] <= bus.ram_data_in_a;
        bus.ram_data_out_b <= mem[bus.ram_addr_b];
    end

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Reference model
    logic [DATA_W-1:0] q[$];
    int unsigned n_wr = 0;
    int unsigned n_rd = 0;
    int unsigned n_ovf = 0;
    int unsigned n_unf = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_flags(input string tag);
        int unsigned n;
        n = q.size();
        check({tag, ":count"}, 32'(bus.count), 32'(n));
        check({tag, ":full"}, 32'(bus.full), 32'(n == DEPTH));
        check({tag, ":empty"}, 32'(bus.empty), 32'(n == 0));
        check({tag, ":afull"}, 32'(bus.almost_full), 32'(n >= 6));
        check({tag, ":aempty"}, 32'(bus.almost_empty), 32'(n <= 2));
    endtask

    // One clock cycle: drive at negedge, check comb RAM drive, then registered results
    task automatic cycle(input logic w, input logic [DATA_W-1:0] d, input logic r);
        bit fm, em, wacc, racc;
        logic [DATA_W-1:0] exp_d;
        @(negedge clk);
        bus.wr_en   = w;
        bus.wr_data = d;
        bus.rd_en   = r;
        #1;
        fm   = (q.size() == DEPTH);
        em   = (q.size() == 0);
        wacc = w && !fm;
        racc = r && !em;
        check("ram_we_a", 32'(bus.ram_we_a), 32'(wacc));
        check("ram_addr_b", 32'(bus.ram_addr_b), n_rd % DEPTH);
        if (wacc) begin
            check("ram_addr_a", 32'(bus.ram_addr_a), n_wr % DEPTH);
            check("ram_data_in_a", 32'(bus.ram_data_in_a), 32'(d));
        end
        exp_d = '0;
        if (racc) begin exp_d = q.pop_front(); n_rd++; end
        if (wacc) begin q.push_back(d); n_wr++; end
        if (w && fm) n_ovf++;
        if (r && em) n_unf++;
        @(posedge clk);
        #1;
        check("rd_valid", 32'(bus.rd_valid), 32'(racc));
        if (racc) check("rd_data", 32'(bus.rd_data), 32'(exp_d));
        check("overflow", 32'(bus.overflow), 32'(w && fm));
        check("underflow", 32'(bus.underflow), 32'(r && em));
        check_flags("post");
    endtask

    initial begin
        bus.wr_en = 1'b0;
        bus.wr_data = '0;
        bus.rd_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst:rd_valid", 32'(bus.rd_valid), 32'd0);
        check("rst:ovf", 32'(bus.overflow), 32'd0);
        check("rst:unf", 32'(bus.underflow), 32'd0);
        check_flags("rst");
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b0, '0, 1'b0);
        check("idle:ram_we_b", 32'(bus.ram_we_b), 32'd0);
        check("idle:ram_data_in_b", 32'(bus.ram_data_in_b), 32'd0);

        // Fill 0x11..0x88, then one write too many
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h11 * (i + 1)), 1'b0);
        cycle(1'b1, 8'h99, 1'b0);
        cycle(1'b0, '0, 1'b0);

        // Drain in order, then one read too many
        for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);

        // Pointer wrap: 5 in/out then 6 in/out
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'hA0 + i), 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b1, 8'(8'hB0 + i), 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1);
        check("wrap:no_ovf", n_ovf, 32'd1);
        check("wrap:no_unf", n_unf, 32'd1);

        // Steady state at count 4 with simultaneous read/write
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'hD0 + i), 1'b1);
        // Both requested while full, then drain and both requested while empty
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'hE0 + i), 1'b0);
        cycle(1'b1, 8'hEE, 1'b1);
        check("full_both:count", 32'(bus.count), 32'd7);
        for (int i = 0; i < 7; i++) cycle(1'b0, '0, 1'b1);
        cycle(1'b1, 8'h5A, 1'b1);
        check("empty_both:count", 32'(bus.count), 32'd1);
        cycle(1'b0, '0, 1'b1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic w, r;
            int unsigned bias;
            bias = (i / 100) % 2 == 0 ? 70 : 30;
            w = ($urandom_range(99) < bias);
            r = ($urandom_range(99) < 100 - bias + 10);
            cycle(w, 8'($urandom), r);
        end

        // Asynchronous reset with count 5 and a read in flight
        while (q.size() > 0) cycle(1'b0, '0, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0);
        cycle(1'b0, '0, 1'b1);
        check("pre_rst:rd_valid", 32'(bus.rd_valid), 32'd1);
        check("pre_rst:count", 32'(bus.count), 32'd5);
        #2;
        rst = 1'b1;
        #1;
        check("arst:rd_valid", 32'(bus.rd_valid), 32'd0);
        check("arst:addr_a", 32'(bus.ram_addr_a), 32'd0);
        check("arst:addr_b", 32'(bus.ram_addr_b), 32'd0);
        q.delete();
        n_wr = 0;
        n_rd = 0;
        check_flags("arst");
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b1, 8'h3C, 1'b0);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
